// File: rtl/dcm_lock_sequencer_if.sv
// Handshake bundle between the DCM lock sequencer and the DCM chain / user logic.
// The sequencer drives the DCM resets and status; the environment drives lock and restart.
interface dcm_lock_sequencer_if #(
    parameter int NUM_STAGES  = 4,
    parameter int MAX_RETRIES = 3
);
    localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    logic [NUM_STAGES-1:0] stage_locked;
    logic                  restart;
    logic [NUM_STAGES-1:0] stage_rst;
    logic                  sys_rst_n;
    logic                  clk_locked;
    logic                  fault;
    logic [SW-1:0]         active_stage;
    logic [RW-1:0]         retry_count;

    modport master (
        input  stage_locked, restart,
        output stage_rst, sys_rst_n, clk_locked, fault, active_stage, retry_count
    );

    modport slave (
        output stage_locked, restart,
        input  stage_rst, sys_rst_n, clk_locked, fault, active_stage, retry_count
    );
endinterface

// File: rtl/dcm_lock_sequencer.sv
// Releases a chain of cascaded DCMs one stage at a time, retries the whole chain on
// lock timeout, re-sequences from the first stage that loses lock, and gates user reset.
module dcm_lock_sequencer #(
    parameter int NUM_STAGES    = 4,
    parameter int RST_CYCLES    = 4,
    parameter int LOCK_TIMEOUT  = 1024,
    parameter int SETTLE_CYCLES = 64,
    parameter int MAX_RETRIES   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dcm_lock_sequencer_if.master bus
);
    localparam int SW      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int RW      = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int M01     = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX = (M01 > SETTLE_CYCLES) ? M01 : SETTLE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [SW-1:0] LAST_STAGE   = SW'(NUM_STAGES - 1);
    localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);
    localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_HOLD, ST_WAIT, ST_SETTLE, ST_RUN, ST_FAULT
    } state_t;

    state_t                state_reg, state_next;
    logic [SW-1:0]         cur_reg, cur_next;
    logic [CW-1:0]         cnt_reg, cnt_next, cnt_inc;
    logic [RW-1:0]         retries_reg, retries_next;
    logic [NUM_STAGES-1:0] sync_reg, lock_s_reg;
    logic [NUM_STAGES-1:0] stage_rst_reg, stage_rst_next;
    logic                  sys_rst_n_reg, sys_rst_n_next;
    logic                  clk_locked_reg, clk_locked_next;
    logic                  fault_reg, fault_next;
    logic                  any_low, lower_low;
    logic [SW-1:0]         low_idx, lower_idx;

    // LOCKED_OUT is asynchronous to the board clock; every decision uses lock_s_reg.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg   <= '0;
            lock_s_reg <= '0;
        end else begin
            sync_reg   <= bus.stage_locked;
            lock_s_reg <= sync_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_HOLD;
            cur_reg        <= '0;
            cnt_reg        <= '0;
            retries_reg    <= '0;
            stage_rst_reg  <= '1;
            sys_rst_n_reg  <= 1'b0;
            clk_locked_reg <= 1'b0;
            fault_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cur_reg        <= cur_next;
            cnt_reg        <= cnt_next;
            retries_reg    <= retries_next;
            stage_rst_reg  <= stage_rst_next;
            sys_rst_n_reg  <= sys_rst_n_next;
            clk_locked_reg <= clk_locked_next;
            fault_reg      <= fault_next;
        end
    end

    // Lowest unlocked stage overall, and lowest unlocked stage below the one being sequenced.
    always_comb begin
        any_low   = 1'b0;
        low_idx   = '0;
        lower_low = 1'b0;
        lower_idx = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (!lock_s_reg[i]) begin
                any_low = 1'b1;
                low_idx = SW'(i);
                if (SW'(i) < cur_reg) begin
                    lower_low = 1'b1;
                    lower_idx = SW'(i);
                end
            end
        end
    end

    assign cnt_inc = (cnt_reg == '1) ? cnt_reg : cnt_reg + CW'(1);

    always_comb begin
        state_next   = state_reg;
        cur_next     = cur_reg;
        cnt_next     = cnt_reg;
        retries_next = retries_reg;
        if (bus.restart) begin
            state_next   = ST_HOLD;
            cur_next     = '0;
            cnt_next     = '0;
            retries_next = '0;
        end else begin
            case (state_reg)
                ST_HOLD: begin
                    if (cnt_reg >= RST_LAST) begin
                        state_next = ST_WAIT;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
                ST_WAIT: begin
                    if (!lock_s_reg[cur_reg] && cnt_reg >= TIMEOUT_LAST) begin
                        cnt_next = '0;
                        if (retries_reg >= RETRY_LIMIT) begin
                            state_next = ST_FAULT;
                        end else begin
                            state_next   = ST_HOLD;
                            cur_next     = '0;
                            retries_next = retries_reg + RW'(1);
                        end
                    end else if (lower_low) begin
                        state_next = ST_HOLD;
                        cur_next   = lower_idx;
                        cnt_next   = '0;
                    end else if (lock_s_reg[cur_reg]) begin
                        if (cur_reg == LAST_STAGE) begin
                            // The cycle that saw the final lock counts as the first settled cycle.
                            state_next = ST_SETTLE;
                            cnt_next   = CW'(1);
                        end else begin
                            state_next = ST_HOLD;
                            cur_next   = cur_reg + SW'(1);
                            cnt_next   = '0;
                        end
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
                ST_SETTLE: begin
                    if (any_low) begin
                        state_next = ST_HOLD;
                        cur_next   = low_idx;
                        cnt_next   = '0;
                    end else if (cnt_reg >= SETTLE_LAST) begin
                        state_next   = ST_RUN;
                        cnt_next     = '0;
                        retries_next = '0;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
                ST_RUN: begin
                    if (any_low) begin
                        state_next = ST_HOLD;
                        cur_next   = low_idx;
                        cnt_next   = '0;
                    end
                end
                ST_FAULT: begin
                    state_next = ST_FAULT;
                end
                default: begin
                    state_next = ST_HOLD;
                    cur_next   = '0;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so that they register together with it.
    always_comb begin
        sys_rst_n_next  = (state_next == ST_RUN);
        clk_locked_next = (state_next == ST_RUN);
        fault_next      = (state_next == ST_FAULT);
    end

    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage_rst
            assign stage_rst_next[gi] = (state_next == ST_FAULT)
                                     || ((state_next == ST_HOLD) && (SW'(gi) >= cur_next))
                                     || ((state_next == ST_WAIT) && (SW'(gi) >  cur_next));
        end
    endgenerate

    assign bus.stage_rst    = stage_rst_reg;
    assign bus.sys_rst_n    = sys_rst_n_reg;
    assign bus.clk_locked   = clk_locked_reg;
    assign bus.fault        = fault_reg;
    assign bus.active_stage = cur_reg;
    assign bus.retry_count  = retries_reg;
endmodule

// File: tb/tb_dcm_lock_sequencer.sv
// Self-checking bench: behavioural DCM models with random lock delays drive the sequencer;
// event timings are checked against arithmetic derived from the sequencing rules.
module tb_dcm_lock_sequencer;
    localparam int N    = 4;
    localparam int RSTC = 4;
    localparam int TOUT = 64;
    localparam int SETL = 16;
    localparam int MAXR = 2;
    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    dcm_lock_sequencer_if #(.NUM_STAGES(N), .MAX_RETRIES(MAXR)) bus ();

    dcm_lock_sequencer #(
        .NUM_STAGES(N), .RST_CYCLES(RSTC), .LOCK_TIMEOUT(TOUT),
        .SETTLE_CYCLES(SETL), .MAX_RETRIES(MAXR)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DCM models and event monitor
    int dly[N];
    bit never_lock[N];
    bit force_low[N];
    int run_cnt[N];
    int rise_cyc[N];
    int lock_in_cyc[N];
    int hold_viol = 0, order_viol = 0, inv_viol = 0, sys_high_cnt = 0;
    int clk_rise_cyc = -1, sys_fall_cyc = -1;
    logic [N-1:0] prev_rst = '1;
    logic prev_clk_locked = 1'b0, prev_sys = 1'b0;

    always @(negedge clk) begin
        bit nl;
        for (int i = 0; i < N; i++) begin
            if (!rst_n || (bus.stage_rst[i] && !prev_rst[i])) rise_cyc[i] = cyc;
            if (!bus.stage_rst[i] && prev_rst[i]) begin
                if (cyc - rise_cyc[i] < RSTC) hold_viol++;
                if (i > 0) begin
                    if (!(bus.stage_locked[i-1] && (cyc - lock_in_cyc[i-1] >= SYNC + 1))) order_viol++;
                end
            end
        end
        if (bus.clk_locked && !prev_clk_locked) clk_rise_cyc = cyc;
        if (!bus.sys_rst_n && prev_sys) sys_fall_cyc = cyc;
        if (bus.sys_rst_n !== bus.clk_locked) inv_viol++;
        if (bus.sys_rst_n) sys_high_cnt++;
        prev_rst        = bus.stage_rst;
        prev_clk_locked = bus.clk_locked;
        prev_sys        = bus.sys_rst_n;
        for (int i = 0; i < N; i++) begin
            if (bus.stage_rst[i] !== 1'b0) begin
                run_cnt[i] = 0;
                nl = 1'b0;
            end else begin
                if (run_cnt[i] < 100000) run_cnt[i]++;
                nl = !never_lock[i] && !force_low[i] && (run_cnt[i] >= dly[i]);
            end
            if (nl && bus.stage_locked[i] !== 1'b1) lock_in_cyc[i] = cyc;
            bus.stage_locked[i] = nl;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic rand_delays();
        for (int i = 0; i < N; i++) begin
            dly[i]        = $urandom_range(20, 2);
            never_lock[i] = 1'b0;
            force_low[i]  = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.restart = 1'b0;
        repeat (3) @(negedge clk);
        hold_viol = 0; order_viol = 0; inv_viol = 0;
        #2 rst_n = 1'b1;
    endtask

    task automatic wait_locked(input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            step();
            ok = (bus.clk_locked === 1'b1);
        end
    endtask

    task automatic test_reset();
        rand_delays();
        rst_n = 1'b0;
        bus.restart = 1'b0;
        repeat (3) step();
        n_vec++; if (bus.stage_rst !== 4'b1111) begin n_err++; $display("FAIL reset_stage_rst: got %b want 1111", bus.stage_rst); end
        n_vec++; if (bus.sys_rst_n !== 1'b0) begin n_err++; $display("FAIL reset_sys_rst_n: got %b want 0", bus.sys_rst_n); end
        n_vec++; if (bus.clk_locked !== 1'b0) begin n_err++; $display("FAIL reset_clk_locked: got %b want 0", bus.clk_locked); end
        n_vec++; if (bus.fault !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %b want 0", bus.fault); end
        n_vec++; if (bus.active_stage !== 2'd0) begin n_err++; $display("FAIL reset_active_stage: got %0d want 0", bus.active_stage); end
        n_vec++; if (bus.retry_count !== 2'd0) begin n_err++; $display("FAIL reset_retry_count: got %0d want 0", bus.retry_count); end
        $display("reset: stage_rst=%b sys_rst_n=%b fault=%b", bus.stage_rst, bus.sys_rst_n, bus.fault);
    endtask

    task automatic test_nominal();
        bit ok;
        for (int it = 0; it < 3; it++) begin
            rand_delays();
            do_reset();
            wait_locked(2000, ok);
            n_vec++; if (!ok) begin n_err++; $display("FAIL nominal_reach_run: clk_locked=%b want 1 within 2000 cycles", bus.clk_locked); end
            n_vec++; if (clk_rise_cyc - lock_in_cyc[N-1] != SYNC + SETL) begin n_err++; $display("FAIL nominal_settle_delay: got %0d want %0d", clk_rise_cyc - lock_in_cyc[N-1], SYNC + SETL); end
            n_vec++; if (bus.sys_rst_n !== 1'b1) begin n_err++; $display("FAIL nominal_sys_rst_n: got %b want 1", bus.sys_rst_n); end
            n_vec++; if (bus.stage_rst !== 4'b0000) begin n_err++; $display("FAIL nominal_stage_rst: got %b want 0000", bus.stage_rst); end
            n_vec++; if (bus.active_stage !== 2'(N - 1)) begin n_err++; $display("FAIL nominal_active_stage: got %0d want %0d", bus.active_stage, N - 1); end
            n_vec++; if (hold_viol != 0) begin n_err++; $display("FAIL nominal_rst_hold: %0d short pulses, want 0", hold_viol); end
            n_vec++; if (order_viol != 0) begin n_err++; $display("FAIL nominal_release_order: %0d early releases, want 0", order_viol); end
            n_vec++; if (inv_viol != 0) begin n_err++; $display("FAIL nominal_sys_vs_locked: %0d cycles differ, want 0", inv_viol); end
            $display("nominal %0d: delays %0d/%0d/%0d/%0d run at cycle %0d", it, dly[0], dly[1], dly[2], dly[3], clk_rise_cyc);
        end
    endtask

    task automatic test_lock_loss();
        bit ok;
        int s, drop_cyc;
        logic [N-1:0] exp_rst;
        rand_delays();
        do_reset();
        wait_locked(2000, ok);
        for (int it = 0; it < 3; it++) begin
            s = $urandom_range(N - 1, 0);
            exp_rst = '0;
            for (int i = 0; i < N; i++) if (i >= s) exp_rst[i] = 1'b1;
            force_low[s] = 1'b1;
            step();
            drop_cyc = cyc;
            ok = 1'b0;
            for (int n = 0; n < 10 && !ok; n++) begin
                if (bus.sys_rst_n === 1'b0) ok = 1'b1; else step();
            end
            n_vec++; if (!ok || cyc - drop_cyc > 3) begin n_err++; $display("FAIL loss_sys_rst_latency: got %0d cycles want <=3", cyc - drop_cyc); end
            n_vec++; if (bus.stage_rst !== exp_rst) begin n_err++; $display("FAIL loss_stage_rst: got %b want %b", bus.stage_rst, exp_rst); end
            n_vec++; if (bus.active_stage !== 2'(s)) begin n_err++; $display("FAIL loss_active_stage: got %0d want %0d", bus.active_stage, s); end
            n_vec++; if (bus.clk_locked !== 1'b0) begin n_err++; $display("FAIL loss_clk_locked: got %b want 0", bus.clk_locked); end
            while (cyc - drop_cyc < 5) step();
            force_low[s] = 1'b0;
            wait_locked(2000, ok);
            n_vec++; if (!ok) begin n_err++; $display("FAIL loss_recover: clk_locked=%b want 1", bus.clk_locked); end
            n_vec++; if (clk_rise_cyc - lock_in_cyc[N-1] != SYNC + SETL) begin n_err++; $display("FAIL loss_settle_delay: got %0d want %0d", clk_rise_cyc - lock_in_cyc[N-1], SYNC + SETL); end
            $display("lock_loss stage %0d: sys_rst_n fell after %0d cycles, rerun at cycle %0d", s, sys_fall_cyc - drop_cyc, clk_rise_cyc);
        end
    endtask

    task automatic test_timeout_fault();
        bit ok;
        int f;
        logic [1:0] prev_rc;
        rand_delays();
        never_lock[2] = 1'b1;
        do_reset();
        for (int r = 1; r <= MAXR + 1; r++) begin
            ok = 1'b0;
            for (int n = 0; n < 400 && !ok; n++) begin step(); ok = (bus.stage_rst[2] === 1'b0); end
            f = cyc;
            n_vec++; if (!ok) begin n_err++; $display("FAIL timeout_stage2_release: attempt %0d never released", r); end
            prev_rc = bus.retry_count;
            ok = 1'b0;
            for (int n = 0; n < 200 && !ok; n++) begin step(); ok = (bus.retry_count !== prev_rc) || (bus.fault === 1'b1); end
            n_vec++; if (!ok || cyc - f != TOUT) begin n_err++; $display("FAIL timeout_latency: got %0d want %0d", cyc - f, TOUT); end
            if (r <= MAXR) begin
                n_vec++; if (bus.retry_count !== 2'(r)) begin n_err++; $display("FAIL timeout_retry_count: got %0d want %0d", bus.retry_count, r); end
            end else begin
                n_vec++; if (bus.fault !== 1'b1) begin n_err++; $display("FAIL timeout_fault: got %b want 1", bus.fault); end
            end
            n_vec++; if (bus.stage_rst !== 4'b1111) begin n_err++; $display("FAIL timeout_stage_rst: got %b want 1111", bus.stage_rst); end
            $display("timeout %0d: retry_count=%0d fault=%b at cycle %0d", r, bus.retry_count, bus.fault, cyc);
        end
        sys_high_cnt = 0;
        repeat (150) step();
        n_vec++; if (bus.fault !== 1'b1) begin n_err++; $display("FAIL fault_sticky: got %b want 1", bus.fault); end
        n_vec++; if (sys_high_cnt != 0) begin n_err++; $display("FAIL fault_sys_rst_n: high %0d cycles want 0", sys_high_cnt); end
        n_vec++; if (bus.clk_locked !== 1'b0) begin n_err++; $display("FAIL fault_clk_locked: got %b want 0", bus.clk_locked); end
        bus.restart = 1'b1;
        step();
        bus.restart = 1'b0;
        n_vec++; if (bus.fault !== 1'b0) begin n_err++; $display("FAIL fault_restart_clear: got %b want 0", bus.fault); end
        n_vec++; if (bus.stage_rst !== 4'b1111) begin n_err++; $display("FAIL fault_restart_stage_rst: got %b want 1111", bus.stage_rst); end
        n_vec++; if (bus.retry_count !== 2'd0) begin n_err++; $display("FAIL fault_restart_retry: got %0d want 0", bus.retry_count); end
        never_lock[2] = 1'b0;
        wait_locked(2000, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL fault_recover: clk_locked=%b want 1", bus.clk_locked); end
        $display("fault: restart cleared fault, run again at cycle %0d", clk_rise_cyc);
    endtask

    task automatic test_restart_in_wait();
        bit ok;
        int w;
        rand_delays();
        dly[2] = 40;
        do_reset();
        ok = 1'b0;
        for (int n = 0; n < 400 && !ok; n++) begin step(); ok = (bus.active_stage === 2'd2) && (bus.stage_rst[2] === 1'b0); end
        w = $urandom_range(25, 0);
        repeat (w) step();
        n_vec++; if (!ok || bus.stage_rst !== 4'b1000) begin n_err++; $display("FAIL restart_wait_reached: got %b want 1000", bus.stage_rst); end
        bus.restart = 1'b1;
        step();
        bus.restart = 1'b0;
        n_vec++; if (bus.stage_rst !== 4'b1111) begin n_err++; $display("FAIL restart_wait_stage_rst: got %b want 1111", bus.stage_rst); end
        n_vec++; if (bus.active_stage !== 2'd0) begin n_err++; $display("FAIL restart_wait_active: got %0d want 0", bus.active_stage); end
        n_vec++; if (bus.retry_count !== 2'd0) begin n_err++; $display("FAIL restart_wait_retry: got %0d want 0", bus.retry_count); end
        wait_locked(2000, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL restart_wait_recover: clk_locked=%b want 1", bus.clk_locked); end
        $display("restart_in_wait: pulsed %0d cycles into WAIT on stage 2", w);
    endtask

    task automatic test_restart_vs_timeout();
        bit ok;
        int f;
        rand_delays();
        never_lock[2] = 1'b1;
        do_reset();
        ok = 1'b0;
        for (int n = 0; n < 1000 && !ok; n++) begin step(); ok = (bus.retry_count === 2'(MAXR)); end
        ok = 1'b0;
        for (int n = 0; n < 400 && !ok; n++) begin step(); ok = (bus.stage_rst[2] === 1'b0); end
        f = cyc;
        n_vec++; if (!ok) begin n_err++; $display("FAIL restart_tout_setup: stage 2 never released on last attempt"); end
        repeat (TOUT - 1) step();
        bus.restart = 1'b1;
        step();
        bus.restart = 1'b0;
        n_vec++; if (bus.fault !== 1'b0) begin n_err++; $display("FAIL restart_tout_fault: got %b want 0", bus.fault); end
        n_vec++; if (bus.retry_count !== 2'd0) begin n_err++; $display("FAIL restart_tout_retry: got %0d want 0", bus.retry_count); end
        n_vec++; if (bus.active_stage !== 2'd0) begin n_err++; $display("FAIL restart_tout_active: got %0d want 0", bus.active_stage); end
        n_vec++; if (bus.stage_rst !== 4'b1111) begin n_err++; $display("FAIL restart_tout_stage_rst: got %b want 1111", bus.stage_rst); end
        never_lock[2] = 1'b0;
        wait_locked(2000, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL restart_tout_recover: clk_locked=%b want 1", bus.clk_locked); end
        $display("restart_vs_timeout: restart at cycle %0d (release at %0d)", f + TOUT, f);
    endtask

    task automatic test_async_reset();
        bit ok;
        rand_delays();
        do_reset();
        ok = 1'b0;
        for (int n = 0; n < 600 && !ok; n++) begin step(); ok = (bus.stage_locked[N-1] === 1'b1); end
        repeat (8) step();
        n_vec++; if (!ok || bus.stage_rst !== 4'b0000 || bus.clk_locked !== 1'b0) begin n_err++; $display("FAIL async_settle_reached: stage_rst=%b clk_locked=%b want 0000/0", bus.stage_rst, bus.clk_locked); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (bus.stage_rst !== 4'b1111) begin n_err++; $display("FAIL async_stage_rst: got %b want 1111", bus.stage_rst); end
        n_vec++; if (bus.active_stage !== 2'd0) begin n_err++; $display("FAIL async_active_stage: got %0d want 0", bus.active_stage); end
        n_vec++; if (bus.sys_rst_n !== 1'b0 || bus.fault !== 1'b0) begin n_err++; $display("FAIL async_sys_fault: sys_rst_n=%b fault=%b want 0/0", bus.sys_rst_n, bus.fault); end
        repeat (2) step();
        hold_viol = 0; order_viol = 0;
        #3 rst_n = 1'b1;
        wait_locked(2000, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL async_recover: clk_locked=%b want 1", bus.clk_locked); end
        n_vec++; if (clk_rise_cyc - lock_in_cyc[N-1] != SYNC + SETL) begin n_err++; $display("FAIL async_settle_delay: got %0d want %0d", clk_rise_cyc - lock_in_cyc[N-1], SYNC + SETL); end
        n_vec++; if (hold_viol != 0 || order_viol != 0) begin n_err++; $display("FAIL async_sequence: hold=%0d order=%0d want 0/0", hold_viol, order_viol); end
        $display("async_reset: resequenced to run at cycle %0d", clk_rise_cyc);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_nominal();
        test_lock_loss();
        test_timeout_fault();
        test_restart_in_wait();
        test_restart_vs_timeout();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
